// File: rtl/pdp8_trace_buffer.sv
// Trace-event collector: round-robin merge of NUM_CH producer channels into a
// sequence-numbered first-word-fall-through FIFO drained over a valid/ready stream.
module pdp8_trace_buffer #(
    parameter int WORD_W       = 12,
    parameter int DEPTH        = 16,
    parameter int NUM_CH       = 2,
    parameter int SEQ_W        = 8,
    parameter int DROP_ON_FULL = 0,
    parameter int STALL_MARGIN = 2,
    parameter int DROP_W       = 8,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                     clock,
    input  logic                     resetN,
    input  logic                     enable,
    input  logic                     flush,
    input  logic [NUM_CH-1:0]        ev_valid,
    input  logic [2*NUM_CH-1:0]      ev_type,
    input  logic [WORD_W*NUM_CH-1:0] ev_addr,
    input  logic [WORD_W*NUM_CH-1:0] ev_data,
    output logic [NUM_CH-1:0]        ev_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH_W-1:0]          out_channel,
    output logic [1:0]               out_type,
    output logic [WORD_W-1:0]        out_addr,
    output logic [WORD_W-1:0]        out_data,
    output logic [SEQ_W-1:0]         out_seq,
    output logic [CNT_W-1:0]         count,
    output logic                     stall_req,
    output logic [DROP_W-1:0]        dropped
);
    localparam int                PTR_W     = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]  FULL_LVL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  STALL_LVL = CNT_W'(DEPTH - STALL_MARGIN);
    localparam logic [DROP_W-1:0] DROP_MAX  = '1;

    logic [CH_W-1:0]   mem_ch   [DEPTH];
    logic [1:0]        mem_type [DEPTH];
    logic [WORD_W-1:0] mem_addr [DEPTH];
    logic [WORD_W-1:0] mem_data [DEPTH];
    logic [SEQ_W-1:0]  mem_seq  [DEPTH];

    logic [1:0]        ch_type [NUM_CH];
    logic [WORD_W-1:0] ch_addr [NUM_CH];
    logic [WORD_W-1:0] ch_data [NUM_CH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   rr_next;
    logic [SEQ_W-1:0]  seq_ctr;

    logic              gnt_vld;
    int                gnt_idx;
    logic [CH_W-1:0]   gnt_sel;
    logic              pop;
    logic              space;
    logic              consume;
    logic              push;
    logic              drop;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_type[i] = ev_type[2*i +: 2];
            ch_addr[i] = ev_addr[WORD_W*i +: WORD_W];
            ch_data[i] = ev_data[WORD_W*i +: WORD_W];
        end
    end

    // Round-robin search: first valid channel at or after rr_ptr.
    always_comb begin : arbiter
        int idx;
        gnt_vld = 1'b0;
        gnt_idx = 0;
        idx     = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!gnt_vld && ev_valid[CH_W'(idx)]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    assign gnt_sel   = CH_W'(gnt_idx);
    assign rr_next   = (gnt_idx == NUM_CH - 1) ? '0 : CH_W'(gnt_idx + 1);

    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign space     = (count != FULL_LVL) | pop;
    // Gating with resetN keeps ev_ready low while the block is held in reset.
    assign consume   = resetN & enable & ~flush & gnt_vld & (space | (DROP_ON_FULL != 0));
    assign push      = consume & space;
    assign drop      = consume & ~space;
    assign stall_req = (DROP_ON_FULL == 0) && (count >= STALL_LVL);

    always_comb begin
        ev_ready = '0;
        if (consume) ev_ready[gnt_sel] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_ch[wr_ptr]   <= gnt_sel;
            mem_type[wr_ptr] <= ch_type[gnt_sel];
            mem_addr[wr_ptr] <= ch_addr[gnt_sel];
            mem_data[wr_ptr] <= ch_data[gnt_sel];
            mem_seq[wr_ptr]  <= seq_ctr;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    // Dropped events still take a sequence number so the host can see the gap.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            seq_ctr <= '0;
            rr_ptr  <= '0;
            dropped <= '0;
        end else begin
            if (consume) begin
                seq_ctr <= seq_ctr + SEQ_W'(1);
                rr_ptr  <= rr_next;
            end
            if (drop && dropped != DROP_MAX) dropped <= dropped + DROP_W'(1);
        end
    end

    assign out_channel = out_valid ? mem_ch[rd_ptr]   : '0;
    assign out_type    = out_valid ? mem_type[rd_ptr] : '0;
    assign out_addr    = out_valid ? mem_addr[rd_ptr] : '0;
    assign out_data    = out_valid ? mem_data[rd_ptr] : '0;
    assign out_seq     = out_valid ? mem_seq[rd_ptr]  : '0;

endmodule

// File: tb/tb_pdp8_trace_buffer.sv
// Bench for pdp8_trace_buffer: a stall-mode and a drop-mode instance share stimulus
// and are compared every cycle against a queue-based model, plus directed sequences.
module tb_pdp8_trace_buffer;
    localparam int W          = 12;
    localparam int DEPTH      = 4;
    localparam int NCH        = 2;
    localparam int A_MARGIN   = 1;
    localparam int B_DROP_W   = 3;
    localparam int B_DROP_MAX = (1 << B_DROP_W) - 1;

    logic             clock = 1'b0;
    logic             resetN;
    logic             enable;
    logic             flush;
    logic             out_ready;
    logic [NCH-1:0]   ev_valid;
    logic [2*NCH-1:0] ev_type;
    logic [W*NCH-1:0] ev_addr;
    logic [W*NCH-1:0] ev_data;

    logic [NCH-1:0]   a_ev_ready, b_ev_ready;
    logic             a_out_valid, b_out_valid;
    logic [0:0]       a_out_channel, b_out_channel;
    logic [1:0]       a_out_type, b_out_type;
    logic [W-1:0]     a_out_addr, b_out_addr;
    logic [W-1:0]     a_out_data, b_out_data;
    logic [7:0]       a_out_seq, b_out_seq;
    logic [2:0]       a_count, b_count;
    logic             a_stall, b_stall;
    logic [7:0]       a_dropped;
    logic [2:0]       b_dropped;

    always #5 clock = ~clock;

    pdp8_trace_buffer #(
        .WORD_W(W), .DEPTH(DEPTH), .NUM_CH(NCH), .SEQ_W(8),
        .DROP_ON_FULL(0), .STALL_MARGIN(A_MARGIN), .DROP_W(8)
    ) dut_a (
        .clock(clock), .resetN(resetN), .enable(enable), .flush(flush),
        .ev_valid(ev_valid), .ev_type(ev_type), .ev_addr(ev_addr), .ev_data(ev_data),
        .ev_ready(a_ev_ready), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_channel(a_out_channel), .out_type(a_out_type), .out_addr(a_out_addr),
        .out_data(a_out_data), .out_seq(a_out_seq), .count(a_count),
        .stall_req(a_stall), .dropped(a_dropped)
    );

    pdp8_trace_buffer #(
        .WORD_W(W), .DEPTH(DEPTH), .NUM_CH(NCH), .SEQ_W(8),
        .DROP_ON_FULL(1), .STALL_MARGIN(2), .DROP_W(B_DROP_W)
    ) dut_b (
        .clock(clock), .resetN(resetN), .enable(enable), .flush(flush),
        .ev_valid(ev_valid), .ev_type(ev_type), .ev_addr(ev_addr), .ev_data(ev_data),
        .ev_ready(b_ev_ready), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_channel(b_out_channel), .out_type(b_out_type), .out_addr(b_out_addr),
        .out_data(b_out_data), .out_seq(b_out_seq), .count(b_count),
        .stall_req(b_stall), .dropped(b_dropped)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one queue of stored events per instance.
    typedef struct packed {
        logic [0:0]   ch;
        logic [1:0]   typ;
        logic [W-1:0] addr;
        logic [W-1:0] data;
        logic [7:0]   seq;
    } ent_t;

    ent_t mq0[$];
    ent_t mq1[$];
    int   mseq[2];
    int   mdrop[2];
    int   mrr[2];
    bit   p_pop[2];
    bit   p_space[2];
    bit   p_cons[2];
    int   p_g[2];

    function automatic void model_reset();
        mq0.delete();
        mq1.delete();
        for (int m = 0; m < 2; m++) begin
            mseq[m]  = 0;
            mdrop[m] = 0;
            mrr[m]   = 0;
        end
    endfunction

    function automatic int qsize(input int m);
        return (m == 0) ? mq0.size() : mq1.size();
    endfunction

    function automatic ent_t qhead(input int m);
        return (m == 0) ? mq0[0] : mq1[0];
    endfunction

    function automatic void predict(input int m);
        int sz;
        sz       = qsize(m);
        p_pop[m] = (sz > 0) && out_ready;
        p_g[m]   = -1;
        for (int k = 0; k < NCH; k++) begin
            int c;
            c = (mrr[m] + k) % NCH;
            if (p_g[m] < 0 && ev_valid[c]) p_g[m] = c;
        end
        p_space[m] = (sz < DEPTH) || p_pop[m];
        p_cons[m]  = resetN && enable && !flush && (p_g[m] >= 0) && (p_space[m] || (m == 1));
    endfunction

    task automatic commit(input int m);
        ent_t q[$];
        ent_t e;
        int   g;
        int   dmax;
        if (m == 0) q = mq0; else q = mq1;
        g    = p_g[m];
        dmax = (m == 0) ? 255 : B_DROP_MAX;
        if (flush) begin
            q.delete();
        end else begin
            if (p_pop[m]) void'(q.pop_front());
            if (p_cons[m] && p_space[m]) begin
                e.ch   = 1'(g);
                e.typ  = ev_type[2*g +: 2];
                e.addr = ev_addr[W*g +: W];
                e.data = ev_data[W*g +: W];
                e.seq  = 8'(mseq[m]);
                q.push_back(e);
            end
        end
        if (p_cons[m]) begin
            mseq[m] = (mseq[m] + 1) % 256;
            mrr[m]  = (g + 1) % NCH;
            if (!p_space[m] && mdrop[m] < dmax) mdrop[m]++;
        end
        if (m == 0) mq0 = q; else mq1 = q;
    endtask

    task automatic check_models();
        for (int m = 0; m < 2; m++) begin
            logic [1:0]   ardy;
            logic         av;
            logic [0:0]   ach;
            logic [1:0]   aty;
            logic [W-1:0] aad;
            logic [W-1:0] ada;
            logic [7:0]   asq;
            int           acnt;
            logic         ast;
            int           adr;
            int           sz;
            ent_t         h;
            string        t;
            predict(m);
            if (m == 0) begin
                t = "A"; ardy = a_ev_ready; av = a_out_valid; ach = a_out_channel; aty = a_out_type;
                aad = a_out_addr; ada = a_out_data; asq = a_out_seq; acnt = int'(a_count);
                ast = a_stall; adr = int'(a_dropped);
            end else begin
                t = "B"; ardy = b_ev_ready; av = b_out_valid; ach = b_out_channel; aty = b_out_type;
                aad = b_out_addr; ada = b_out_data; asq = b_out_seq; acnt = int'(b_count);
                ast = b_stall; adr = int'(b_dropped);
            end
            sz = qsize(m);
            chk({t, ".ev_ready"}, 32'(ardy), p_cons[m] ? 32'(1 << p_g[m]) : 32'd0);
            chk({t, ".out_valid"}, 32'(av), 32'(sz > 0));
            chk({t, ".count"}, 32'(acnt), 32'(sz));
            chk({t, ".stall_req"}, 32'(ast), 32'((m == 0) && (sz >= DEPTH - A_MARGIN)));
            chk({t, ".dropped"}, 32'(adr), 32'(mdrop[m]));
            if (sz > 0) begin
                h = qhead(m);
                chk({t, ".out_channel"}, 32'(ach), 32'(h.ch));
                chk({t, ".out_type"}, 32'(aty), 32'(h.typ));
                chk({t, ".out_addr"}, 32'(aad), 32'(h.addr));
                chk({t, ".out_data"}, 32'(ada), 32'(h.data));
                chk({t, ".out_seq"}, 32'(asq), 32'(h.seq));
            end
        end
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic cycle();
        #1;
        check_models();
        @(posedge clock);
        commit(0);
        commit(1);
        @(negedge clock);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".A.ev_ready"}, 32'(a_ev_ready), 32'd0);
        chk({tag, ".A.out_valid"}, 32'(a_out_valid), 32'd0);
        chk({tag, ".A.payload"}, 32'({a_out_channel, a_out_type, a_out_addr, a_out_seq}), 32'd0);
        chk({tag, ".A.out_data"}, 32'(a_out_data), 32'd0);
        chk({tag, ".A.count"}, 32'(a_count), 32'd0);
        chk({tag, ".A.stall_req"}, 32'(a_stall), 32'd0);
        chk({tag, ".A.dropped"}, 32'(a_dropped), 32'd0);
        chk({tag, ".B.ev_ready"}, 32'(b_ev_ready), 32'd0);
        chk({tag, ".B.out_valid"}, 32'(b_out_valid), 32'd0);
        chk({tag, ".B.payload"}, 32'({b_out_channel, b_out_type, b_out_addr, b_out_seq}), 32'd0);
        chk({tag, ".B.out_data"}, 32'(b_out_data), 32'd0);
        chk({tag, ".B.count"}, 32'(b_count), 32'd0);
        chk({tag, ".B.dropped"}, 32'(b_dropped), 32'd0);
    endtask

    // Asynchronous reset pulse starting between clock edges; called at a falling edge.
    task automatic reset_mid();
        ev_valid = '1;
        enable   = 1'b1;
        #2;
        resetN = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        model_reset();
        @(negedge clock);
        @(negedge clock);
        resetN   = 1'b1;
        ev_valid = '0;
    endtask

    typedef struct {
        logic [1:0]   vld;
        logic [W-1:0] a0;
        logic [W-1:0] a1;
        logic         rdy;
        logic [1:0]   x_rdy;
        logic         x_vld;
        int           x_cnt;
        logic         x_stall;
        int           x_seq;
        logic [W-1:0] x_addr;
    } vec_t;

    function automatic vec_t mkv(input logic [1:0] vld, input logic [W-1:0] a0, input logic [W-1:0] a1,
                                 input logic rdy, input logic [1:0] xr, input logic xv, input int xc,
                                 input logic xs, input int xq, input logic [W-1:0] xa);
        vec_t v;
        v.vld = vld; v.a0 = a0; v.a1 = a1; v.rdy = rdy;
        v.x_rdy = xr; v.x_vld = xv; v.x_cnt = xc; v.x_stall = xs; v.x_seq = xq; v.x_addr = xa;
        return v;
    endfunction

    vec_t vt[12];

    initial begin
        resetN = 1'b0; enable = 1'b0; flush = 1'b0; out_ready = 1'b0;
        ev_valid = '0; ev_type = '0; ev_addr = '0; ev_data = '0;
        model_reset();

        // Stall instance: alternate grants, fill, stall the 5th event, then drain.
        vt[0]  = mkv(2'b11, 12'o200, 12'o400, 1'b0, 2'b01, 1'b0, 0, 1'b0, 0, 12'o0);
        vt[1]  = mkv(2'b11, 12'o201, 12'o400, 1'b0, 2'b10, 1'b1, 1, 1'b0, 0, 12'o200);
        vt[2]  = mkv(2'b11, 12'o201, 12'o401, 1'b0, 2'b01, 1'b1, 2, 1'b0, 0, 12'o200);
        vt[3]  = mkv(2'b11, 12'o202, 12'o401, 1'b0, 2'b10, 1'b1, 3, 1'b1, 0, 12'o200);
        vt[4]  = mkv(2'b01, 12'o202, 12'o401, 1'b0, 2'b00, 1'b1, 4, 1'b1, 0, 12'o200);
        vt[5]  = mkv(2'b01, 12'o202, 12'o401, 1'b0, 2'b00, 1'b1, 4, 1'b1, 0, 12'o200);
        vt[6]  = mkv(2'b01, 12'o202, 12'o401, 1'b1, 2'b01, 1'b1, 4, 1'b1, 0, 12'o200);
        vt[7]  = mkv(2'b00, 12'o203, 12'o402, 1'b1, 2'b00, 1'b1, 4, 1'b1, 1, 12'o400);
        vt[8]  = mkv(2'b00, 12'o203, 12'o402, 1'b1, 2'b00, 1'b1, 3, 1'b1, 2, 12'o201);
        vt[9]  = mkv(2'b00, 12'o203, 12'o402, 1'b1, 2'b00, 1'b1, 2, 1'b0, 3, 12'o401);
        vt[10] = mkv(2'b00, 12'o203, 12'o402, 1'b1, 2'b00, 1'b1, 1, 1'b0, 4, 12'o202);
        vt[11] = mkv(2'b00, 12'o203, 12'o402, 1'b1, 2'b00, 1'b0, 0, 1'b0, 0, 12'o0);

        @(negedge clock);
        chk_reset_vals("reset");
        @(negedge clock);
        resetN  = 1'b1;
        enable  = 1'b1;
        ev_type = {2'b11, 2'b01};

        for (int i = 0; i < 12; i++) begin
            ev_valid  = vt[i].vld;
            ev_addr   = {vt[i].a1, vt[i].a0};
            ev_data   = {vt[i].a1 ^ 12'o7777, vt[i].a0 ^ 12'o7777};
            out_ready = vt[i].rdy;
            #1;
            chk($sformatf("tbl%0d.ev_ready", i), 32'(a_ev_ready), 32'(vt[i].x_rdy));
            chk($sformatf("tbl%0d.out_valid", i), 32'(a_out_valid), 32'(vt[i].x_vld));
            chk($sformatf("tbl%0d.count", i), 32'(a_count), 32'(vt[i].x_cnt));
            chk($sformatf("tbl%0d.stall_req", i), 32'(a_stall), 32'(vt[i].x_stall));
            if (vt[i].x_vld) begin
                chk($sformatf("tbl%0d.out_seq", i), 32'(a_out_seq), 32'(vt[i].x_seq));
                chk($sformatf("tbl%0d.out_addr", i), 32'(a_out_addr), 32'(vt[i].x_addr));
            end
            cycle();
        end

        // Reset mid-stream with two entries held.
        ev_valid = 2'b01; out_ready = 1'b0;
        cycle();
        cycle();
        chk("rst.count_before", 32'(a_count), 32'd2);
        reset_mid();
        ev_valid = 2'b01; ev_addr = {12'o400, 12'o1234};
        cycle();
        chk("rst.first_seq_A", 32'(a_out_seq), 32'd0);
        chk("rst.first_seq_B", 32'(b_out_seq), 32'd0);
        chk("rst.dropped_B", 32'(b_dropped), 32'd0);

        // Drop mode: fill, discard three, drain, then one more event.
        reset_mid();
        ev_valid = 2'b01; out_ready = 1'b0; enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ev_addr = {12'o400, 12'(12'o300 + i)};
            cycle();
        end
        for (int i = 0; i < 3; i++) begin
            ev_addr = {12'o400, 12'(12'o310 + i)};
            #1;
            chk("drop.ev_ready", 32'(b_ev_ready), 32'd1);
            chk("drop.stall_ready", 32'(a_ev_ready), 32'd0);
            cycle();
        end
        chk("drop.dropped", 32'(b_dropped), 32'd3);
        chk("drop.stall_req_B", 32'(b_stall), 32'd0);
        ev_valid = 2'b00; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drop.drain_seq", 32'(b_out_seq), 32'(i));
            cycle();
        end
        ev_valid = 2'b01; out_ready = 1'b0;
        cycle();
        chk("drop.next_seq", 32'(b_out_seq), 32'd7);
        chk("drop.stall_next_seq", 32'(a_out_seq), 32'd4);
        ev_valid = 2'b00; out_ready = 1'b1;
        cycle();

        // Flush while pushing and popping.
        ev_valid = 2'b10; out_ready = 1'b0;
        repeat (3) cycle();
        chk("flush.count_before", 32'(a_count), 32'd3);
        flush = 1'b1; out_ready = 1'b1;
        #1;
        chk("flush.ev_ready", 32'(a_ev_ready), 32'd0);
        cycle();
        flush = 1'b0; ev_valid = 2'b00; out_ready = 1'b0;
        chk("flush.count", 32'(a_count), 32'd0);
        chk("flush.out_valid", 32'(a_out_valid), 32'd0);
        ev_valid = 2'b10;
        cycle();
        chk("flush.next_seq_A", 32'(a_out_seq), 32'd8);
        chk("flush.next_seq_B", 32'(b_out_seq), 32'd11);
        ev_valid = 2'b00; out_ready = 1'b1;
        cycle();

        // Randomised traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            enable    = ($urandom_range(0, 9) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            out_ready = ($urandom_range(0, 99) < 45);
            ev_valid  = 2'($urandom_range(0, 3));
            ev_type   = 4'($urandom);
            ev_addr   = 24'($urandom);
            ev_data   = 24'($urandom);
            if ($urandom_range(0, 799) == 0) reset_mid();
            else cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
